// File: rtl/ex_me_pipe_if.sv
// rtl/ex_me_pipe_if.sv - EX-to-ME handshake bundle between the EX stage, the pipe register and the ME stage
interface ex_me_pipe_if #(
    parameter int W = 139
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_bus;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_bus;
    logic         flush;
    logic [1:0]   occupancy;

    // View taken by the pipe register itself.
    modport slave (
        input  in_valid,
        input  in_bus,
        input  out_ready,
        input  flush,
        output in_ready,
        output out_valid,
        output out_bus,
        output occupancy
    );

    // View taken by the surrounding EX/ME logic.
    modport master (
        output in_valid,
        output in_bus,
        output out_ready,
        output flush,
        input  in_ready,
        input  out_valid,
        input  out_bus,
        input  occupancy
    );
endinterface

// File: rtl/ex_me_pipe.sv
// rtl/ex_me_pipe.sv - EX-to-ME pipeline register; EX_ME_SKID_EN selects a two-entry skid buffer
module ex_me_pipe #(
    parameter int W = 139
) (
    input  logic             clk,
    input  logic             rst_n,
    ex_me_pipe_if.slave      io_pipe
);

    // State value doubles as the occupancy count.
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
`ifdef EX_ME_SKID_EN
    localparam logic [1:0] S_TWO   = 2'd2;
`endif

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic         r_alive;
    logic [W-1:0] r_main;
`ifdef EX_ME_SKID_EN
    logic [W-1:0] r_skid;
    logic         w_load_skid;
    logic         w_load_main_skid;
`endif
    logic         w_load_main_in;
    logic         w_in_ready;
    logic         w_out_valid;
    logic         w_in_fire;
    logic         w_out_fire;

    // Handshake outputs; r_alive keeps in_ready low until the first edge after reset.
    always_comb begin
        w_out_valid = (r_state != S_EMPTY);
`ifdef EX_ME_SKID_EN
        // Skid version: in_ready comes from registered state only.
        w_in_ready  = r_alive & (r_state != S_TWO);
`else
        // Single-entry version: the held entry can be replaced in the cycle it leaves.
        w_in_ready  = r_alive & ((r_state == S_EMPTY) | io_pipe.out_ready);
`endif
        w_in_fire   = io_pipe.in_valid & w_in_ready;
        w_out_fire  = w_out_valid & io_pipe.out_ready;
    end

    // Next-state and payload-load decode; flush overrides every other event.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
`ifdef EX_ME_SKID_EN
        w_load_skid      = 1'b0;
        w_load_main_skid = 1'b0;
`endif
        if (io_pipe.flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt    = S_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                S_ONE: begin
                    case ({w_in_fire, w_out_fire})
                        2'b11: begin
                            w_state_nxt    = S_ONE;
                            w_load_main_in = 1'b1;
                        end
`ifdef EX_ME_SKID_EN
                        2'b10: begin
                            w_state_nxt = S_TWO;
                            w_load_skid = 1'b1;
                        end
`endif
                        2'b01: begin
                            w_state_nxt = S_EMPTY;
                        end
                        default: begin
                            w_state_nxt = S_ONE;
                        end
                    endcase
                end
`ifdef EX_ME_SKID_EN
                S_TWO: begin
                    if (w_out_fire) begin
                        w_state_nxt      = S_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
`endif
                default: begin
                    w_state_nxt = S_EMPTY;
                end
            endcase
        end
    end

    // Control state: asynchronously cleared so outputs drop the moment reset asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Reset-release marker: in_ready is allowed high from the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
        end
    end

    // Main payload register: no reset, only loaded on an accepted transfer.
    always_ff @(posedge clk) begin
        if (w_load_main_in) begin
            r_main <= io_pipe.in_bus;
`ifdef EX_ME_SKID_EN
        end else if (w_load_main_skid) begin
            r_main <= r_skid;
`endif
        end
    end

`ifdef EX_ME_SKID_EN
    // Skid payload register: catches the bus accepted while main is stalled.
    always_ff @(posedge clk) begin
        if (w_load_skid) begin
            r_skid <= io_pipe.in_bus;
        end
    end
`endif

    assign io_pipe.in_ready  = w_in_ready;
    assign io_pipe.out_valid = w_out_valid;
    assign io_pipe.out_bus   = r_main;
    assign io_pipe.occupancy = r_state;

endmodule

// File: tb/tb_ex_me_pipe.sv
// tb/tb_ex_me_pipe.sv - scoreboard bench for ex_me_pipe in either EX_ME_SKID_EN setting
module tb_ex_me_pipe;
    localparam int W = 139;
`ifdef EX_ME_SKID_EN
    localparam int MAX_OCC = 2;
`else
    localparam int MAX_OCC = 1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ex_me_pipe_if #(.W(W)) pif ();
    ex_me_pipe #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .io_pipe(pif));

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int n_drop   = 0;
    int n_out    = 0;
    logic [W-1:0] sb[$];

    function automatic logic [W-1:0] mk(input logic [31:0] v);
        return W'({v, ~v, v, ~v, v});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_bus(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_until_accept(input string name);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            acc = pif.in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        pif.in_valid = 1'b0;
        chk(name, {31'd0, acc}, 32'd1);
    endtask

    task automatic wait_empty(input string name);
        logic done;
        done = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (pif.occupancy == 2'd0 && pif.out_valid == 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        step();
        chk(name, {31'd0, done}, 32'd1);
    endtask

    // Monitor: every presented output must match the oldest pending entry; pop on consume.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("occ_bound", {31'd0, (int'(pif.occupancy) <= MAX_OCC)}, 32'd1);
            if (pif.out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_out: out_bus=%h with nothing pending", pif.out_bus);
                end else begin
                    chk_bus("out_bus_order", pif.out_bus, sb[0]);
                    if (pif.out_ready === 1'b1) begin
                        void'(sb.pop_front());
                        n_out++;
                    end
                end
            end
        end
    end

    // Input side: record accepted payloads; reset and flush discard everything held.
    always @(negedge clk) begin
        #1;
        if (rst_n !== 1'b1 || pif.flush === 1'b1) begin
            n_drop += sb.size();
            sb.delete();
        end else if (pif.in_valid === 1'b1 && pif.in_ready === 1'b1) begin
            sb.push_back(pif.in_bus);
            n_acc++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int seq;
        rst_n         = 1'b0;
        pif.in_valid  = 1'b0;
        pif.in_bus    = '0;
        pif.out_ready = 1'b0;
        pif.flush     = 1'b0;

        // Reset state
        #2;
        chk("rst_out_valid", {31'd0, pif.out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, pif.in_ready},  32'd0);
        chk("rst_occ",       {30'd0, pif.occupancy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready",  {31'd0, pif.in_ready},  32'd1);
        chk("post_rst_out_valid", {31'd0, pif.out_valid}, 32'd0);

        // Single transfer, one cycle latency
        pif.out_ready = 1'b1;
        pif.in_valid  = 1'b1;
        pif.in_bus    = mk(32'h1234);
        step();
        pif.in_valid  = 1'b0;
        pif.in_bus    = mk(32'hBAD0_0001);
        chk("single_out_valid", {31'd0, pif.out_valid}, 32'd1);
        chk("single_occ",       {30'd0, pif.occupancy}, 32'd1);
        chk_bus("single_out_bus", pif.out_bus, mk(32'h1234));
        step();
        chk("single_after_valid", {31'd0, pif.out_valid}, 32'd0);

        // Back-pressure: A, B, C delivered in order exactly once
        base = n_out;
        pif.out_ready = 1'b0;
        pif.in_valid  = 1'b1;
        pif.in_bus    = mk(32'hA0);
        step();
        pif.in_bus    = mk(32'hB0);
        step();
`ifdef EX_ME_SKID_EN
        chk("bp_occ_full",      {30'd0, pif.occupancy}, 32'd2);
        chk("bp_in_ready_full", {31'd0, pif.in_ready},  32'd0);
        pif.in_bus = mk(32'hC0);
        step();
        step();
        chk("bp_occ_hold",      {30'd0, pif.occupancy}, 32'd2);
        chk("bp_in_ready_hold", {31'd0, pif.in_ready},  32'd0);
        chk_bus("bp_stall_bus", pif.out_bus, mk(32'hA0));
        pif.out_ready = 1'b1;
        hold_until_accept("bp_accept_c");
`else
        chk("bp_occ_full",      {30'd0, pif.occupancy}, 32'd1);
        chk("bp_in_ready_full", {31'd0, pif.in_ready},  32'd0);
        step();
        step();
        chk("bp_occ_hold",      {30'd0, pif.occupancy}, 32'd1);
        chk("bp_in_ready_hold", {31'd0, pif.in_ready},  32'd0);
        chk_bus("bp_stall_bus", pif.out_bus, mk(32'hA0));
        pif.out_ready = 1'b1;
        hold_until_accept("bp_accept_b");
        pif.in_valid = 1'b1;
        pif.in_bus   = mk(32'hC0);
        hold_until_accept("bp_accept_c");
`endif
        wait_empty("bp_drain");
        chk("bp_out_count", n_out - base, 32'd3);

        // Streaming 0..99 without bubbles
        base = n_out;
        pif.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            pif.in_valid = 1'b1;
            pif.in_bus   = mk(i);
            @(negedge clk);
            chk("stream_in_ready", {31'd0, pif.in_ready}, 32'd1);
            if (i > 0) chk("stream_out_valid", {31'd0, pif.out_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        pif.in_valid = 1'b0;
        @(negedge clk);
        chk("stream_last_valid", {31'd0, pif.out_valid}, 32'd1);
        step();
        chk("stream_count", n_out - base, 32'd100);
        chk("stream_end_occ", {30'd0, pif.occupancy}, 32'd0);

        // Flush with the buffer full, in_valid high carrying D
        pif.out_ready = 1'b0;
        pif.in_valid  = 1'b1;
        pif.in_bus    = mk(32'hE0);
        step();
`ifdef EX_ME_SKID_EN
        pif.in_bus = mk(32'hF0);
        step();
`endif
        chk("flush_pre_occ", {30'd0, pif.occupancy}, MAX_OCC);
        pif.flush  = 1'b1;
        pif.in_bus = mk(32'hD0);
        step();
        pif.flush    = 1'b0;
        pif.in_valid = 1'b0;
        chk("flush_occ",       {30'd0, pif.occupancy}, 32'd0);
        chk("flush_out_valid", {31'd0, pif.out_valid}, 32'd0);
        pif.out_ready = 1'b1;
        repeat (3) begin
            step();
            chk("flush_quiet", {31'd0, pif.out_valid}, 32'd0);
        end

        // Flush from EMPTY while an input would otherwise be accepted
        pif.in_valid = 1'b1;
        pif.in_bus   = mk(32'hD2);
        pif.flush    = 1'b1;
        step();
        pif.flush    = 1'b0;
        pif.in_valid = 1'b0;
        chk("flush_empty_occ",   {30'd0, pif.occupancy}, 32'd0);
        chk("flush_empty_valid", {31'd0, pif.out_valid}, 32'd0);

        // Asynchronous reset while full
        pif.out_ready = 1'b0;
        pif.in_valid  = 1'b1;
        pif.in_bus    = mk(32'h60);
        step();
`ifdef EX_ME_SKID_EN
        pif.in_bus = mk(32'h61);
        step();
`endif
        pif.in_valid = 1'b0;
        chk("arst_pre_occ", {30'd0, pif.occupancy}, MAX_OCC);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, pif.out_valid}, 32'd0);
        chk("arst_in_ready",  {31'd0, pif.in_ready},  32'd0);
        chk("arst_occ",       {30'd0, pif.occupancy}, 32'd0);
        step();
        step();
        rst_n         = 1'b1;
        pif.out_ready = 1'b1;
        step();
        chk("arst_rel_in_ready", {31'd0, pif.in_ready}, 32'd1);
        repeat (3) begin
            chk("arst_no_stale", {31'd0, pif.out_valid}, 32'd0);
            step();
        end

        // Random valid/ready stress; invalid cycles carry junk that must be ignored
        seq = 0;
        for (int c = 0; c < 400; c++) begin
            pif.in_valid  = 1'($urandom_range(0, 1));
            pif.out_ready = ($urandom_range(0, 3) != 0);
            pif.in_bus    = pif.in_valid ? mk(32'h5000_0000 + seq) : mk(32'hDEAD_0000 | $urandom_range(0, 16'hFFFF));
            @(negedge clk);
            if (pif.in_valid && pif.in_ready) seq++;
            @(posedge clk);
            #1;
        end
        pif.in_valid  = 1'b0;
        pif.out_ready = 1'b1;
        wait_empty("stress_drain");
        chk("stress_progress", {31'd0, (seq > 50)}, 32'd1);

        chk("sb_empty", sb.size(), 32'd0);
        chk("exactly_once", n_out, n_acc - n_drop);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_me_pipe.md
EX_ME_PIPE -- requirements
Module: ex_me_pipe

Interface
REQ-001 The block SHALL have parameter W, default 139, giving the width of the EX-to-ME bus carried opaquely.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the EX stage presents a valid bus.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts in_bus this cycle.
REQ-006 The block SHALL have port in_bus, input, W bits: the EX-to-ME payload.
REQ-007 The block SHALL have port out_valid, output, 1 bit: out_bus is valid for the ME stage.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the ME stage consumes out_bus this cycle.
REQ-009 The block SHALL have port out_bus, output, W bits: the payload presented to the ME stage.
REQ-010 The block SHALL have port flush, input, 1 bit: discard all held entries (trap/redirect).
REQ-011 The block SHALL have port occupancy, output, 2 bits: the number of entries held (0..2).

Function
REQ-012 The block SHALL define transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-013 The block SHALL hold a main entry (drives out_bus) and, with the macro enabled, one skid entry; state is EMPTY, ONE or TWO.
REQ-014 In EMPTY the block SHALL drive out_valid=0 and in_ready=1; in_fire moves the state to ONE with main<=in_bus.
REQ-015 In ONE the block SHALL drive out_valid=1 and in_ready=1, with these transitions: in_fire&out_fire stays ONE with main<=in_bus; in_fire alone moves to TWO with skid<=in_bus; out_fire alone moves to EMPTY.
REQ-016 In TWO the block SHALL drive out_valid=1 and in_ready=0; out_fire moves the state to ONE with main<=skid.
REQ-017 in_ready SHALL be a function of registered state only, with no combinational path from out_ready.
REQ-018 Latency SHALL be one cycle: a bus accepted in EMPTY appears on out_bus with out_valid=1 in the next cycle.
REQ-019 Order SHALL be preserved: every accepted payload is presented exactly once, never dropped or duplicated (ME performs store side effects).
REQ-020 While out_valid=1 and out_ready=0, out_bus SHALL be held bit-stable.
REQ-021 in_bus SHALL be ignored whenever in_valid=0.
REQ-022 flush SHALL have priority over all events: the next state is EMPTY, and any in_fire in the same cycle is discarded.
REQ-023 occupancy SHALL equal 0/1/2 for EMPTY/ONE/TWO.
REQ-024 Sustained in_valid=out_ready=1 SHALL give one transfer per cycle with no bubbles.

Reset
REQ-025 Assertion of rst_n=0 SHALL asynchronously force state to EMPTY, out_valid=0, in_ready=0 and occupancy=0.
REQ-026 in_ready SHALL rise to 1 in the first cycle after rst_n deasserts.
REQ-027 Payload registers SHALL NOT be reset; out_bus is don't-care while out_valid=0.
REQ-028 Reset during TWO SHALL discard both entries, with no output transfer afterwards.

Configuration
REQ-029 When macro EX_ME_SKID_EN is defined, the block SHALL implement the two-entry skid behaviour of REQ-013..REQ-017.
REQ-030 When EX_ME_SKID_EN is undefined, the block SHALL implement a single entry (states EMPTY/ONE only), drive in_ready = (state==EMPTY) | out_ready combinationally, and keep occupancy <= 1.
REQ-031 All other requirements SHALL hold in both configurations.

Verification
REQ-032 Single transfer: reset, then in_valid=1 with in_bus=0x...1234 for one cycle and out_ready=1 -> out_valid=1 with out_bus=0x...1234 the next cycle, then out_valid=0.
REQ-033 Back-pressure: push A, B with out_ready=0 -> occupancy=2 and in_ready=0 (skid build); C is held off; then out_ready=1 -> A, B, C are output in order, each exactly once.
REQ-034 Streaming: 100 consecutive payloads 0..99 with in_valid=out_ready=1 -> 100 consecutive out_fire cycles carry 0..99, with no gaps after the first.
REQ-035 Flush: with occupancy=2, assert flush together with in_valid=1 (payload D) -> the next cycle has occupancy=0 and out_valid=0, and D never appears.
REQ-036 Async reset: drop rst_n mid-cycle in TWO -> out_valid=0 and in_ready=0 immediately; after release in_ready=1 and no stale output appears.
REQ-037 Random valid/ready stress in both macro settings -> the output sequence equals the accepted input sequence, and out_bus is stable under stall.
